// File: rtl/instr_prefetch_buffer_if.sv
// Prefetch buffer bundle: redirect, instruction memory request/response
// and decode-side output, with the buffer as master.
interface instr_prefetch_buffer_if;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        instr_req_valid_o;
    logic        instr_req_ready_i;
    logic [31:0] instr_req_addr_o;
    logic        instr_rsp_valid_i;
    logic        instr_rsp_ready_o;
    logic [31:0] instr_rsp_data_i;
    logic        instr_rsp_error_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic        out_error_o;
    logic [31:0] stall_cnt_o;

    modport master (
        input  flush_i, flush_pc_i, instr_req_ready_i,
        input  instr_rsp_valid_i, instr_rsp_data_i, instr_rsp_error_i,
        input  out_ready_i,
        output instr_req_valid_o, instr_req_addr_o, instr_rsp_ready_o,
        output out_valid_o, out_instr_o, out_pc_o, out_error_o,
        output stall_cnt_o
    );

    modport slave (
        output flush_i, flush_pc_i, instr_req_ready_i,
        output instr_rsp_valid_i, instr_rsp_data_i, instr_rsp_error_i,
        output out_ready_i,
        input  instr_req_valid_o, instr_req_addr_o, instr_rsp_ready_o,
        input  out_valid_o, out_instr_o, out_pc_o, out_error_o,
        input  stall_cnt_o
    );
endinterface

// File: rtl/instr_prefetch_buffer.sv
// In-order instruction prefetch FIFO with flush/discard and fault halt.
// Optional decode starvation counter: define PREFETCH_STALL_CNT_EN.
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic clk_i,
    input logic rst_ni,
    instr_prefetch_buffer_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    logic [0:0]    state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   rsp_pc_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] outstanding_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] discard_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW:0]   inflight;
    logic [31:0]   flush_pc;
    logic          req_hs;
    logic          rsp_hs;
    logic          push;
    logic          pop;
    logic          out_valid;

    logic [31:0] data_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];
    logic        err_mem  [DEPTH];

    assign inflight = {1'b0, outstanding_q} + {1'b0, count_q};
    assign flush_pc = bus.flush_pc_i & 32'hFFFF_FFFC;

    assign bus.instr_req_valid_o = rst_ni && (state_q == RUN) && !bus.flush_i
                                 && (32'(inflight) < DEPTH);
    assign bus.instr_req_addr_o  = fetch_pc_q;
    assign bus.instr_rsp_ready_o = 1'b1;

    assign req_hs = bus.instr_req_valid_o && bus.instr_req_ready_i;
    assign rsp_hs = bus.instr_rsp_valid_i;
    // Responses in the redirect cycle or owed to old requests are dropped
    assign push   = rsp_hs && !bus.flush_i && (discard_q == '0);
    assign pop    = out_valid && bus.out_ready_i && !bus.flush_i;

    assign outstanding_d = outstanding_q + CW'(req_hs) - CW'(rsp_hs);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            count_q       <= '0;
            discard_q     <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (bus.flush_i) begin
                state_q    <= RUN;
                fetch_pc_q <= flush_pc;
                rsp_pc_q   <= flush_pc;
                count_q    <= '0;
                discard_q  <= outstanding_d;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
            end else begin
                if (req_hs)
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                if (rsp_hs && (discard_q != '0))
                    discard_q <= discard_q - CW'(1);
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                    rsp_pc_q <= rsp_pc_q + 32'd4;
                    if (bus.instr_rsp_error_i)
                        state_q <= HALT;
                end
                if (pop)
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr_q] <= bus.instr_rsp_data_i;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
            err_mem[wr_ptr_q]  <= bus.instr_rsp_error_i;
        end
    end

    assign out_valid       = (count_q != '0);
    assign bus.out_valid_o = out_valid;
    assign bus.out_instr_o = out_valid ? data_mem[rd_ptr_q] : 32'd0;
    assign bus.out_pc_o    = out_valid ? pc_mem[rd_ptr_q] : 32'd0;
    assign bus.out_error_o = out_valid && err_mem[rd_ptr_q];

`ifdef PREFETCH_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            stall_q <= '0;
        else if (bus.out_ready_i && !out_valid && (stall_q != 32'hFFFF_FFFF))
            stall_q <= stall_q + 32'd1;
    end

    assign bus.stall_cnt_o = stall_q;
`else
    assign bus.stall_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: memory model, FIFO scoreboard,
// fill table and redirect/fault sequences.
module tb_instr_prefetch_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } ent_t;

    typedef struct {
        logic        ordy;
        logic        rv;
        logic [31:0] addr;
        logic        ov;
        logic [31:0] opc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_prefetch_buffer_if bus();

    instr_prefetch_buffer #(
        .DEPTH(DEPTH),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .bus(bus)
    );

    mreq_t       mq[$];
    ent_t        exp_q[$];
    logic [31:0] hs_log[$];
    logic [31:0] pop_log[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pop_total = 0;
    logic [31:0] mpc;
    logic [31:0] mstall;
    bit          mhalt;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          rnd_mem = 0;
    bit          rnd_dec = 0;
    bit          dec_rdy = 1;
    bit          err_en = 0;
    bit          err_rule = 0;
    logic [31:0] err_addr = 32'h0;
    bit          do_flush = 0;
    logic [31:0] fl_pc = 32'h0;
    logic [31:0] err_pc_seen;

    function automatic logic [31:0] word(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic is_err(logic [31:0] a);
        return (err_en && a == err_addr) || (err_rule && a[5:2] == 4'd11);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic drive();
        @(negedge clk);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.instr_rsp_valid_i = 1'b1;
            bus.instr_rsp_data_i  = word(mq[0].addr);
            bus.instr_rsp_error_i = is_err(mq[0].addr);
        end else begin
            bus.instr_rsp_valid_i = 1'b0;
            bus.instr_rsp_data_i  = 32'h0;
            bus.instr_rsp_error_i = 1'b0;
        end
        bus.flush_i           = do_flush;
        bus.flush_pc_i        = fl_pc;
        bus.instr_req_ready_i = rnd_mem ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.out_ready_i       = rnd_dec ? 1'($urandom_range(0, 1)) : dec_rdy;
        #1;
    endtask

    task automatic model_check();
        logic rv;
        rv = !mhalt && !do_flush && (mq.size() + exp_q.size() < DEPTH);
        chk("req_valid", 32'(bus.instr_req_valid_o), 32'(rv));
        if (rv)
            chk("req_addr", bus.instr_req_addr_o, mpc);
        chk("rsp_ready", 32'(bus.instr_rsp_ready_o), 32'd1);
        chk("out_valid", 32'(bus.out_valid_o), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("out_instr", bus.out_instr_o, exp_q[0].instr);
            chk("out_pc", bus.out_pc_o, exp_q[0].pc);
            chk("out_error", 32'(bus.out_error_o), 32'(exp_q[0].err));
        end
`ifdef PREFETCH_STALL_CNT_EN
        chk("stall_cnt", bus.stall_cnt_o, mstall);
`else
        chk("stall_cnt", bus.stall_cnt_o, 32'd0);
`endif
    endtask

    task automatic commit();
        bit    pop;
        mreq_t e;
        ent_t  en;
        pop = exp_q.size() != 0 && bus.out_ready_i && !do_flush;
        if (bus.out_ready_i && exp_q.size() == 0 && mstall != 32'hFFFF_FFFF)
            mstall++;
        if (pop) begin
            if (bus.out_error_o)
                err_pc_seen = bus.out_pc_o;
            pop_log.push_back(exp_q[0].pc);
            void'(exp_q.pop_front());
            pop_total++;
        end
        if (bus.instr_rsp_valid_i && mq.size() > 0) begin
            e = mq.pop_front();
            if (!e.stale && !do_flush) begin
                en.instr = word(e.addr);
                en.pc    = e.addr;
                en.err   = is_err(e.addr);
                exp_q.push_back(en);
                if (en.err)
                    mhalt = 1;
            end
        end
        if (bus.instr_req_valid_o && bus.instr_req_ready_i) begin
            e.addr  = mpc;
            e.due   = cyc + $urandom_range(lat_min, lat_max);
            e.stale = 0;
            mq.push_back(e);
            hs_log.push_back(mpc);
            mpc = mpc + 32'd4;
        end
        if (do_flush) begin
            foreach (mq[i]) mq[i].stale = 1;
            exp_q.delete();
            pop_log.delete();
            hs_log.delete();
            mhalt = 0;
            mpc   = fl_pc & 32'hFFFF_FFFC;
        end
        cyc++;
    endtask

    task automatic cycle(int n);
        for (int i = 0; i < n; i++) begin
            drive();
            model_check();
            commit();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.flush_i = 1'b0;
        bus.flush_pc_i = 32'h0;
        bus.instr_req_ready_i = 1'b1;
        bus.instr_rsp_valid_i = 1'b0;
        bus.instr_rsp_data_i = 32'h0;
        bus.instr_rsp_error_i = 1'b0;
        bus.out_ready_i = 1'b1;
        mq.delete();
        exp_q.delete();
        hs_log.delete();
        pop_log.delete();
        mpc = 32'h0;
        mstall = 32'h0;
        mhalt = 0;
        do_flush = 0;
        err_en = 0;
        err_rule = 0;
        rnd_mem = 0;
        rnd_dec = 0;
        dec_rdy = 1;
        lat_min = 1;
        lat_max = 1;
        err_pc_seen = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(bus.instr_req_valid_o), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_out_instr", bus.out_instr_o, 32'd0);
        chk("rst_out_pc", bus.out_pc_o, 32'd0);
        chk("rst_out_error", 32'(bus.out_error_o), 32'd0);
        chk("rst_stall", bus.stall_cnt_o, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    function automatic logic [31:0] q0(logic [31:0] q[$], int idx);
        return (q.size() > idx) ? q[idx] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        vec_t tbl[10];
        int   p0;
        bit   seen;

        // Fill with decode stalled, then a single pop
        tbl[0] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
        tbl[3] = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
        tbl[4] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
        tbl[5] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
        tbl[6] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
        tbl[7] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h0};
        tbl[8] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h4};
        tbl[9] = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h4};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            dec_rdy = tbl[i].ordy;
            drive();
            model_check();
            chk($sformatf("tbl%0d_rv", i), 32'(bus.instr_req_valid_o), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_addr", i), bus.instr_req_addr_o, tbl[i].addr);
            chk($sformatf("tbl%0d_ov", i), 32'(bus.out_valid_o), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_pc", i), bus.out_pc_o, tbl[i].opc);
            commit();
        end

        // Streaming with one-cycle memory
        do_reset();
        cycle(8);
        chk("stream_hs0", q0(hs_log, 0), 32'h0);
        chk("stream_hs1", q0(hs_log, 1), 32'h4);
        chk("stream_hs2", q0(hs_log, 2), 32'h8);
        chk("stream_hs3", q0(hs_log, 3), 32'hC);
        chk("stream_pop0", q0(pop_log, 0), 32'h0);
        chk("stream_pop1", q0(pop_log, 1), 32'h4);

        // Redirect with two requests in flight
        do_reset();
        lat_min = 5;
        lat_max = 5;
        cycle(2);
        do_flush = 1;
        fl_pc = 32'h103;
        cycle(1);
        do_flush = 0;
        cycle(15);
        chk("flush_hs0", q0(hs_log, 0), 32'h100);
        chk("flush_pop0", q0(pop_log, 0), 32'h100);

        // Fetch fault halts until redirected
        do_reset();
        err_en = 1;
        err_addr = 32'h8;
        cycle(12);
        chk("fault_hs_count", 32'(hs_log.size()), 32'd4);
        chk("fault_pc", err_pc_seen, 32'h8);
        do_flush = 1;
        fl_pc = 32'h200;
        cycle(1);
        do_flush = 0;
        err_en = 0;
        cycle(6);
        chk("resume_hs0", q0(hs_log, 0), 32'h200);

        // Redirect coinciding with a response, target near wrap
        do_reset();
        lat_min = 2;
        lat_max = 2;
        cycle(2);
        do_flush = 1;
        fl_pc = 32'hFFFF_FFFC;
        drive();
        chk("flush_rsp_present", 32'(bus.instr_rsp_valid_i), 32'd1);
        model_check();
        commit();
        do_flush = 0;
        cycle(12);
        chk("wrap_pop0", q0(pop_log, 0), 32'hFFFF_FFFC);
        chk("wrap_pop1", q0(pop_log, 1), 32'h0);

        // Starvation count at first valid, memory latency 3
        do_reset();
        lat_min = 3;
        lat_max = 3;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            drive();
            model_check();
            if (bus.out_valid_o) begin
                seen = 1;
`ifdef PREFETCH_STALL_CNT_EN
                chk("stall_first_valid", bus.stall_cnt_o, 32'd4);
`else
                chk("stall_first_valid", bus.stall_cnt_o, 32'd0);
`endif
            end
            commit();
        end
        chk("stall_seen_valid", 32'(seen), 32'd1);

        // Random soak with flushes and periodic faults
        do_reset();
        rnd_mem = 1;
        rnd_dec = 1;
        lat_min = 1;
        lat_max = 4;
        err_rule = 1;
        p0 = pop_total;
        for (int i = 0; i < 600; i++) begin
            do_flush = ($urandom_range(0, 19) == 0);
            fl_pc = $urandom();
            cycle(1);
        end
        do_flush = 0;
        chk("soak_activity", 32'(pop_total - p0 > 30), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end
endmodule
